// File: rtl/aes_pkg.sv
// Shared AES definitions for the MixColumns stage.
//   StateW     : width of the AES state (16 bytes)
//   WordW      : width of one state column (4 bytes)
//   GfPoly     : low byte of the GF(2^8) reduction polynomial x^8+x^4+x^3+x+1
//   mc_state_e : mixcolumn FSM encoding
//   xtime      : multiply a byte by {02} in GF(2^8)
package aes_pkg;

  localparam int unsigned StateW = 128;
  localparam int unsigned WordW  = 32;
  localparam logic [7:0]  GfPoly = 8'h1B;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GfPoly : 8'h00);
  endfunction

endpackage

// File: rtl/mixcol_word.sv
// Combinational MixColumns transform of a single 32-bit state column.
// Byte 0 of the column sits in bits [31:24].
// Ports:
//   data_in  : input column
//   inv      : 1 selects InvMixColumns (present only with MIXCOL_INV_EN)
//   data_out : transformed column
// Build option: MIXCOL_INV_EN adds the inverse transform and the inv port.
module mixcol_word
  import aes_pkg::*;
(
  input  logic [WordW-1:0] data_in,
`ifdef MIXCOL_INV_EN
  input  logic             inv,
`endif
  output logic [WordW-1:0] data_out
);

  // Row r of the forward matrix is [02 03 01 01] rotated right by r, so each
  // output byte is 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3] with indices mod 4.
  function automatic logic [7:0] fwd_byte(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3);
    return xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
  endfunction

  logic [7:0] b0, b1, b2, b3;
  logic [WordW-1:0] fwd_word;

  assign b0 = data_in[31:24];
  assign b1 = data_in[23:16];
  assign b2 = data_in[15:8];
  assign b3 = data_in[7:0];

  assign fwd_word = {fwd_byte(b0, b1, b2, b3), fwd_byte(b1, b2, b3, b0),
                     fwd_byte(b2, b3, b0, b1), fwd_byte(b3, b0, b1, b2)};

`ifdef MIXCOL_INV_EN
  // Inverse row is [0E 0B 0D 09] rotated; products built from xtime chains.
  function automatic logic [7:0] inv_byte(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] p0, p1, p2, p3;
    p0 = xtime(xtime(xtime(a0))) ^ xtime(xtime(a0)) ^ xtime(a0);  // 0E
    p1 = xtime(xtime(xtime(a1))) ^ xtime(a1) ^ a1;                // 0B
    p2 = xtime(xtime(xtime(a2))) ^ xtime(xtime(a2)) ^ a2;         // 0D
    p3 = xtime(xtime(xtime(a3))) ^ a3;                            // 09
    return p0 ^ p1 ^ p2 ^ p3;
  endfunction

  logic [WordW-1:0] inv_word;

  assign inv_word = {inv_byte(b0, b1, b2, b3), inv_byte(b1, b2, b3, b0),
                     inv_byte(b2, b3, b0, b1), inv_byte(b3, b0, b1, b2)};

  assign data_out = inv ? inv_word : fwd_word;
`else
  assign data_out = fwd_word;
`endif

endmodule

// File: rtl/mixcolumn.sv
// AES MixColumns stage: processes one column per clock, four clocks per state.
// A start (ok_shift) is accepted in idle or done; the state and the final-round
// flag are captured, then columns 0..3 are transformed through one shared
// mixcol_word instance. The full result is published on plain_col with ok_col
// at the fourth edge after the accepting edge and held until the next start.
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   plain_shift : input state from ShiftRows, byte 0 in bits [128:121]
//   ok_shift    : start request, plain_shift valid while high
//   is_last     : final round, columns pass through unchanged
//   decrypt     : select InvMixColumns (present only with MIXCOL_INV_EN)
//   plain_col   : registered result
//   ok_col      : result valid level
//   busy        : columns in flight
// Build option: MIXCOL_INV_EN adds the decrypt input and inverse transform.
module mixcolumn
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [StateW:1] plain_shift,
  input  logic            ok_shift,
  input  logic            is_last,
`ifdef MIXCOL_INV_EN
  input  logic            decrypt,
`endif
  output logic [StateW:1] plain_col,
  output logic            ok_col,
  output logic            busy
);

  mc_state_e        state_q;
  logic [1:0]       col_idx_q;
  logic [StateW:1]  src_q;
  logic [StateW:1]  work_q, work_d;
  logic             last_q;
`ifdef MIXCOL_INV_EN
  logic             dec_q;
`endif
  logic [WordW-1:0] col_src, col_mix, col_res;

  always_comb begin
    col_src = src_q[128:97];
    case (col_idx_q)
      2'd0:    col_src = src_q[128:97];
      2'd1:    col_src = src_q[96:65];
      2'd2:    col_src = src_q[64:33];
      default: col_src = src_q[32:1];
    endcase
  end

  mixcol_word u_word (
    .data_in  (col_src),
`ifdef MIXCOL_INV_EN
    .inv      (dec_q),
`endif
    .data_out (col_mix)
  );

  assign col_res = last_q ? col_src : col_mix;

  // Working register with the current column replaced; on the last column this
  // is the complete result and goes straight to plain_col.
  always_comb begin
    work_d = work_q;
    case (col_idx_q)
      2'd0:    work_d[128:97] = col_res;
      2'd1:    work_d[96:65]  = col_res;
      2'd2:    work_d[64:33]  = col_res;
      default: work_d[32:1]   = col_res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      col_idx_q <= 2'd0;
      src_q     <= '0;
      work_q    <= '0;
      last_q    <= 1'b0;
`ifdef MIXCOL_INV_EN
      dec_q     <= 1'b0;
`endif
      plain_col <= '0;
      ok_col    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (ok_shift) begin
            src_q     <= plain_shift;
            last_q    <= is_last;
`ifdef MIXCOL_INV_EN
            dec_q     <= decrypt;
`endif
            ok_col    <= 1'b0;
            col_idx_q <= 2'd0;
            busy      <= 1'b1;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          work_q <= work_d;
          if (col_idx_q == 2'd3) begin
            plain_col <= work_d;
            ok_col    <= 1'b1;
            busy      <= 1'b0;
            col_idx_q <= 2'd0;
            state_q   <= StDone;
          end else begin
            col_idx_q <= col_idx_q + 2'd1;
          end
        end
        default: begin
          state_q   <= StIdle;
          col_idx_q <= 2'd0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mixcolumn.sv
// Bench for mixcolumn: directed vectors plus random traffic, checked by a
// scoreboard fed from a byte-level GF(2^8) reference model.
module tb_mixcolumn;

  logic         clk;
  logic         rst;
  logic [128:1] plain_shift;
  logic         ok_shift;
  logic         is_last;
`ifdef MIXCOL_INV_EN
  logic         decrypt;
`endif
  logic [128:1] plain_col;
  logic         ok_col;
  logic         busy;

  mixcolumn dut (
    .clk         (clk),
    .rst         (rst),
    .plain_shift (plain_shift),
    .ok_shift    (ok_shift),
    .is_last     (is_last),
`ifdef MIXCOL_INV_EN
    .decrypt     (decrypt),
`endif
    .plain_col   (plain_col),
    .ok_col      (ok_col),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [128:1] data;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [128:1] model(input logic [128:1] d, input bit last, input bit dec);
    logic [7:0]   m [4];
    logic [7:0]   a [4];
    logic [7:0]   o;
    logic [128:1] r;
    if (last) return d;
    if (dec) begin
      m[0] = 8'h0E; m[1] = 8'h0B; m[2] = 8'h0D; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = d[128 - 8 * (4 * c + k) -: 8];
      for (int row = 0; row < 4; row++) begin
        o = 8'h00;
        for (int k = 0; k < 4; k++) o = o ^ gmul(m[(k - row + 4) % 4], a[k]);
        r[128 - 8 * (4 * c + row) -: 8] = o;
      end
    end
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising ok_col must match the oldest outstanding expectation.
  logic ok_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (ok_col === 1'b1 && ok_prev !== 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ok_col: got rise at cycle %0d expected none", cyc);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (plain_col !== e.data) begin
          errors++;
          $display("FAIL result: got %h expected %h", plain_col, e.data);
        end
        if (cyc - e.cyc != 4) begin
          errors++;
          $display("FAIL latency: got %0d expected 4", cyc - e.cyc);
        end
      end
    end
    ok_prev = ok_col;
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [128:1] d, input bit last, input bit dec);
    int           c;
    logic [128:1] prev;
    @(negedge clk);
    plain_shift = d;
    is_last     = last;
`ifdef MIXCOL_INV_EN
    decrypt     = dec;
`endif
    ok_shift    = 1'b1;
    prev        = plain_col;
    c           = cyc + 1;
    @(posedge clk);
    sb_q.push_back('{data: model(d, last, dec), cyc: c});
    @(negedge clk);
    ok_shift = 1'b0;
    chk("busy_after_accept", {127'd0, busy}, 128'd1);
    chk("ok_col_cleared", {127'd0, ok_col}, 128'd0);
    chk("plain_col_held_busy", plain_col, prev);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ok_col === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_within_bound", {127'd0, seen}, 128'd1);
  endtask

  function automatic logic [128:1] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [128:1] VecIn   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [128:1] VecOut  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [128:1] Vec2In  = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [128:1] Vec2Out = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

  initial begin
    logic [128:1] d;
    logic [128:1] e;
    int           c;
    bit           dec_r;

    rst         = 1'b1;
    ok_shift    = 1'b1;  // reset must win over a start request
    is_last     = 1'b0;
    plain_shift = VecIn;
`ifdef MIXCOL_INV_EN
    decrypt     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_ok_col", {127'd0, ok_col}, 128'd0);
    chk("reset_busy", {127'd0, busy}, 128'd0);
    chk("reset_plain_col", plain_col, 128'd0);
    rst      = 1'b0;
    ok_shift = 1'b0;

    // Known FIPS-197 vector, checked against a literal expectation.
    @(negedge clk);
    plain_shift = VecIn;
    is_last     = 1'b0;
    ok_shift    = 1'b1;
    c           = cyc + 1;
    @(posedge clk);
    sb_q.push_back('{data: VecOut, cyc: c});
    @(negedge clk);
    ok_shift = 1'b0;
    wait_done();

    // Column vectors, literal expectation.
    @(negedge clk);
    plain_shift = Vec2In;
    ok_shift    = 1'b1;
    c           = cyc + 1;
    @(posedge clk);
    sb_q.push_back('{data: Vec2Out, cyc: c});
    @(negedge clk);
    ok_shift = 1'b0;
    wait_done();

    // Final round bypass.
    issue(VecIn, 1'b1, 1'b0);
    wait_done();
    chk("bypass_equals_input", plain_col, VecIn);

    // Starts during BUSY cycles 1 and 2 must be ignored.
    d = rnd128();
    issue(d, 1'b0, 1'b0);
    ok_shift    = 1'b1;
    plain_shift = rnd128();
    @(negedge clk);
    @(negedge clk);
    ok_shift = 1'b0;
    wait_done();
    e = model(d, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    chk("ok_col_held_done", {127'd0, ok_col}, 128'd1);
    chk("plain_col_held_done", plain_col, e);

    // ok_shift held high through completion: back-to-back restarts.
    @(negedge clk);
    d           = rnd128();
    plain_shift = d;
    is_last     = 1'b0;
    ok_shift    = 1'b1;
    c           = cyc + 1;
    @(posedge clk);
    sb_q.push_back('{data: model(d, 1'b0, 1'b0), cyc: c});
    for (int i = 0; i < 2; i++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      d           = rnd128();
      plain_shift = d;
      c           = cyc + 1;
      @(posedge clk);
      sb_q.push_back('{data: model(d, 1'b0, 1'b0), cyc: c});
      @(negedge clk);
      chk("ok_col_one_cycle", {127'd0, ok_col}, 128'd0);
      chk("busy_on_restart", {127'd0, busy}, 128'd1);
    end
    ok_shift = 1'b0;
    wait_done();

    // Reset in BUSY cycle 2 aborts with no result.
    issue(rnd128(), 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    chk("abort_ok_col", {127'd0, ok_col}, 128'd0);
    chk("abort_plain_col", plain_col, 128'd0);
    chk("abort_busy", {127'd0, busy}, 128'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_result", {127'd0, ok_col}, 128'd0);
    issue(VecIn, 1'b0, 1'b0);
    wait_done();

`ifdef MIXCOL_INV_EN
    issue(VecOut, 1'b0, 1'b1);
    wait_done();
    chk("inverse_vector", plain_col, VecIn);
`endif

    // Random traffic.
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
`ifdef MIXCOL_INV_EN
      dec_r = 1'($urandom_range(0, 1));
`else
      dec_r = 1'b0;
`endif
      issue(rnd128(), ($urandom_range(0, 3) == 0), dec_r);
      wait_done();
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 128'(sb_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mixcolumn.md
MIXCOLUMN -- requirements
Module: mixcolumn

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock (the only clock).
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: plain_shift  in  [128:1]  state from the ShiftRows stage.
REQ-004 SHALL have ports: ok_shift  in  1  start request; plain_shift is valid while high.
REQ-005 SHALL have ports: is_last  in  1  final round; MixColumns is bypassed.
REQ-006 SHALL have ports: plain_col  out  [128:1]  registered result, feeding AddRoundKey.
REQ-007 SHALL have ports: ok_col  out  1  result valid; a level held until the next accepted start.
REQ-008 SHALL have ports: busy  out  1  high while columns are being processed.
REQ-009 SHALL use byte order: bits [128:121] = byte 0; column c = bytes 4c..4c+3; column 0 = bits [128:97].

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE; BUSY carries a 2-bit column counter col_idx.
REQ-011 SHALL accept a start only when ok_shift=1 in IDLE or DONE; the accepting edge captures plain_shift and is_last, clears ok_col, sets col_idx=0, and enters BUSY.
REQ-012 SHALL process one column per clock in BUSY, col_idx 0..3, writing the result into an internal working register.
REQ-013 SHALL compute each column per FIPS-197: GF(2^8) matrix [02 03 01 01] rotated, reduction polynomial 0x11B.
REQ-014 SHALL, when the captured is_last=1, pass each column through unchanged, with identical timing.
REQ-015 SHALL, at the edge where col_idx=3 completes, load plain_col with the full result, set ok_col=1, drop busy, and enter DONE; latency is 4 clocks from the accepting edge.
REQ-016 SHALL hold plain_col and ok_col stable in DONE until the next accepted start.
REQ-017 SHALL ignore ok_shift while BUSY; no queuing, and the in-flight operation is unaffected.
REQ-018 SHALL, when ok_shift is held high in DONE, restart on the next edge, so ok_col is high for exactly 1 cycle.
REQ-019 SHALL leave plain_col unchanged while BUSY; only the completion edge updates it.
REQ-020 SHALL keep col_idx wrap 3->0 only by the BUSY->DONE transition; no free-running counting.

Reset
REQ-021 SHALL, when rst=1 at a clock edge, set state=IDLE, col_idx=0, ok_col=0, busy=0, plain_col=0, working register=0.
REQ-022 SHALL give rst priority over ok_shift; reset mid-BUSY aborts the operation, and no ok_col follows.
REQ-023 SHALL, on the first edge with rst=0 and ok_shift=1, accept normally.

Configuration
REQ-024 SHALL support macro MIXCOL_INV_EN.
REQ-025 SHALL, when MIXCOL_INV_EN is defined: add input decrypt (1 bit, captured at accept); decrypt=1 selects InvMixColumns, matrix [0E 0B 0D 09]; timing is unchanged.
REQ-026 SHALL, when MIXCOL_INV_EN is undefined: have no decrypt port, and perform forward MixColumns only.

Structure
REQ-027 SHALL take state width 128, the FSM state encoding, and the constant 8'h1B from shared package aes_pkg.
REQ-028 SHALL put the single-column transform in combinational sub-module mixcol_word (32-bit in/out, plus inverse select under MIXCOL_INV_EN), instantiated once and time-shared across col_idx.

Verification
REQ-029 SHALL cover: plain_shift=d4bf5d30e0b452aeb84111f11e2798e5, is_last=0 -> plain_col=046681e5e0cb199a48f8d37a2806264c, ok_col rising 4 clocks after accept.
REQ-030 SHALL cover: columns db135345 / f20a225c / 01010101 / c6c6c6c6 -> 8e4da1bc / 9fdc589d / 01010101 / c6c6c6c6.
REQ-031 SHALL cover: the same input with is_last=1 -> plain_col equals the input, at the same 4-clock latency.
REQ-032 SHALL cover: ok_shift pulsed at BUSY cycles 1 and 2 -> ignored, and only one ok_col rise occurs, carrying the first input.
REQ-033 SHALL cover: rst at BUSY cycle 2 -> next edge shows ok_col=0 and plain_col=0; a restart then gives the correct result.
REQ-034 SHALL cover, with MIXCOL_INV_EN defined and decrypt=1: input 046681e5e0cb199a48f8d37a2806264c -> d4bf5d30e0b452aeb84111f11e2798e5.
